seg_scan_mux: RTL

Parametrised time-multiplexed scanner for common-anode seven-segment displays, successor to the fixed 2-to-4 digit-select decoder. It holds a refresh prescaler and a digit index and drives a one-hot digit enable with programmable polarity. It also decodes each digit's 4-bit value to segments and inserts an anti-ghosting dead time between digits. It sits between the clock/time-keeping logic and the Basys3 anode/segment pins.

---
 rtl/seg_scan_mux_if.sv | 38 +++
 rtl/seg_scan_mux.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg_scan_mux_if.sv
// Digit scanner bus: display data in, anode/segment drive and scan status out.
//   master : producer of digit data / consumer of display drive (e.g. testbench)
//   slave  : seg_scan_mux side
// Signals:
//   enable      1 = scan, 0 = freeze scan with display dark
//   digits_in   4 bits per digit, digit k at [4k+3:4k], digit 0 rightmost
//   dp_in       per-digit decimal point request (1 = lit)
//   blank_mask  per-digit blank (1 = segments and dp dark)
//   anode       one-hot digit enable (polarity set by the scanner)
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point
//   digit_sel   index of the digit owning the current slot
//   frame_tick  one-cycle pulse when the scan wraps to digit 0
interface seg_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_DIGITS);

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              seg;
  logic                    dp;
  logic [SEL_W-1:0]        digit_sel;
  logic                    frame_tick;

  modport master (
    output enable, digits_in, dp_in, blank_mask,
    input  anode, seg, dp, digit_sel, frame_tick
  );

  modport slave (
    input  enable, digits_in, dp_in, blank_mask,
    output anode, seg, dp, digit_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner with hex decode, per-digit blanking
// and an anti-ghosting dead time at the start of every digit slot.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (all drive outputs go inactive)
//   bus    seg_scan_mux_if slave: digit data in, anode/seg/dp/status out
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SEL_W       = $clog2(NUM_DIGITS),
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_mux_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(REFRESH_DIV);
  localparam logic             INV      = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [SEL_W-1:0]      digit_sel_q, digit_sel_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  live;
  logic [NUM_DIGITS-1:0] anode_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;

  // Hex digit to active-high segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Next scan state, and output drive computed from that next state so the
  // registered outputs always describe the slot the counters are in.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_tick_d = 1'b0;
    anode_hi     = '0;
    seg_hi       = '0;
    dp_hi        = 1'b0;

    if (bus.enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d        = '0;
          frame_tick_d = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Dead time keeps all anodes off while the previous digit's charge drains.
    live = bus.enable &&
           !((DEAD_CYCLES != 0) && (cnt_d < CNT_W'(DEAD_CYCLES)));

    // Explicit compare per digit so indices beyond NUM_DIGITS never select.
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (live && (idx_d == SEL_W'(k))) begin
        anode_hi[k] = 1'b1;
        if (!bus.blank_mask[k]) begin
          seg_hi = glyph(bus.digits_in[4*k +: 4]);
          dp_hi  = bus.dp_in[k];
        end
      end
    end

    anode_d     = anode_hi ^ {NUM_DIGITS{INV}};
    seg_d       = seg_hi ^ {7{INV}};
    dp_d        = dp_hi ^ INV;
    digit_sel_d = idx_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      anode_q      <= {NUM_DIGITS{INV}};
      seg_q        <= {7{INV}};
      dp_q         <= INV;
      digit_sel_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
